// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding-select encodings and the forwarding priority helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MISS     = 2'd2
  } hazard_state_e;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Youngest producer wins: MEM result beats WB data; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] dst_m,
                                         input logic       we_m,
                                         input logic [4:0] dst_w,
                                         input logic       we_w);
    logic [1:0] sel;
    sel = FWD_REG;
    if (src != 5'd0) begin
      if (we_m && (dst_m == src)) begin
        sel = FWD_MEM;
      end else if (we_w && (dst_w == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running enable counter, wraps at 2^CNT_W.
// Ports: clk, rst (async, active-high), en_i (count this cycle), count_o.
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline.
// Inputs: ID/EX/MEM/WB register ids and write enables, load flag in EX,
//   branch/jalr taken in EX, jal in ID, data-cache miss.
// Outputs: bubble*/flush* per segment register (combinational from state
//   and inputs), EX operand forwarding selects, stall/miss performance
//   counters and a sticky miss-timeout error flag.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MISS_TIMEOUT = 1024,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       reg1_srcD,
  input  logic [4:0]       reg2_srcD,
  input  logic [1:0]       reg_read_enD,
  input  logic [4:0]       reg1_srcE,
  input  logic [4:0]       reg2_srcE,
  input  logic [4:0]       reg_dstE,
  input  logic [4:0]       reg_dstM,
  input  logic [4:0]       reg_dstW,
  input  logic             reg_write_enE,
  input  logic             reg_write_enM,
  input  logic             reg_write_enW,
  input  logic             wb_selectE,
  input  logic             br_takenE,
  input  logic             jalD,
  input  logic             dcache_miss,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [1:0]       op1_sel,
  output logic [1:0]       op2_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] miss_cycles,
  output logic             err_timeout
);

  localparam int unsigned RUN_W = $clog2(MISS_TIMEOUT + 1);

  hazard_state_e    state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             err_q, err_d;
  logic             load_use;

  // EX load feeds a source register the ID instruction actually reads.
  assign load_use = wb_selectE && reg_write_enE && (reg_dstE != 5'd0) &&
                    ((reg_read_enD[0] && (reg1_srcD == reg_dstE)) ||
                     (reg_read_enD[1] && (reg2_srcD == reg_dstE)));

  // Next state and pipeline controls; priority miss > branch > load-use > jal.
  always_comb begin
    state_d = ST_RUN;
    {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b00000;
    {flushF, flushD, flushE, flushM, flushW}      = 5'b00000;
    op1_sel = FWD_REG;
    op2_sel = FWD_REG;
    if (rst) begin
      {flushF, flushD, flushE, flushM, flushW} = 5'b11111;
    end else begin
      op1_sel = fwd_sel(reg1_srcE, reg_dstM, reg_write_enM, reg_dstW, reg_write_enW);
      op2_sel = fwd_sel(reg2_srcE, reg_dstM, reg_write_enM, reg_dstW, reg_write_enW);
      if (dcache_miss) begin
        {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = 5'b11111;
        state_d = ST_MISS;
      end else if (br_takenE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (load_use && (state_q != ST_LU_STALL)) begin
        // The held pair is not stalled a second time.
        bubbleF = 1'b1;
        bubbleD = 1'b1;
        flushE  = 1'b1;
        state_d = ST_LU_STALL;
      end else if (jalD) begin
        flushD = 1'b1;
      end
    end
  end

  // Consecutive-miss run length, saturating at the timeout; err is sticky.
  always_comb begin
    run_d = '0;
    if (dcache_miss) begin
      run_d = (run_q == RUN_W'(MISS_TIMEOUT)) ? run_q : run_q + RUN_W'(1);
    end
    err_d = err_q || (run_d == RUN_W'(MISS_TIMEOUT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign err_timeout = err_q;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (bubbleF),
    .count_o (stall_cycles)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (dcache_miss),
    .count_o (miss_cycles)
  );

endmodule
